// File: rtl/alu_share_if.sv
// alu_share_if: request, shared-ALU and response signals for the two-requester ALU share arbiter
interface alu_share_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_alu_op;
  logic [5:0]        req0_func;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [TAG_W-1:0]  req0_tag;
  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_alu_op;
  logic [5:0]        req1_func;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [TAG_W-1:0]  req1_tag;
  logic [3:0]        alu_op;
  logic [5:0]        func_code;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_err;
  modport slave (
    input  req0_valid, req0_alu_op, req0_func, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_alu_op, req1_func, req1_a, req1_b, req1_tag,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_op, func_code, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err
  );
  modport master (
    output req0_valid, req0_alu_op, req0_func, req0_a, req0_b, req0_tag,
    output req1_valid, req1_alu_op, req1_func, req1_a, req1_b, req1_tag,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_op, func_code, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters, one op in flight.
// Define ILLEGAL_FUNC_TRAP_EN to reject illegal ops with an error response instead of issuing them.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input logic        i_clk,
  input logic        i_rst,
  alu_share_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t            r_state, w_next;
  logic              r_prio, r_id, r_err;
  logic [3:0]        r_op;
  logic [5:0]        r_func;
  logic [DATA_W-1:0] r_a, r_b, r_result;
  logic [TAG_W-1:0]  r_tag;
  logic              w_g0, w_g1, w_grant, w_illegal;
  logic [3:0]        w_op;
  logic [5:0]        w_func;
  // Prio only breaks ties; a lone valid requester is granted regardless
  assign w_g0    = (r_state == IDLE) && io_bus.req0_valid && (!io_bus.req1_valid || !r_prio);
  assign w_g1    = (r_state == IDLE) && io_bus.req1_valid && (!io_bus.req0_valid || r_prio);
  assign w_grant = w_g0 || w_g1;
  assign w_op    = w_g1 ? io_bus.req1_alu_op : io_bus.req0_alu_op;
  assign w_func  = w_g1 ? io_bus.req1_func : io_bus.req0_func;
`ifdef ILLEGAL_FUNC_TRAP_EN
  assign w_illegal = (w_op == 4'b0101) || ((w_op == 4'b1111) && !(w_func inside
    {6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}));
`else
  assign w_illegal = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (w_grant ? (w_illegal ? RESP : ISSUE) : IDLE) :
             r_state == ISSUE ? RESP :
             r_state == RESP  ? (io_bus.rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prio   <= 1'b0;
      r_id     <= 1'b0;
      r_err    <= 1'b0;
      r_op     <= '0;
      r_func   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_result <= '0;
    end else begin
      if (w_grant) begin
        r_id     <= w_g1;
        r_prio   <= !w_g1;
        r_tag    <= w_g1 ? io_bus.req1_tag : io_bus.req0_tag;
        r_err    <= w_illegal;
        r_result <= '0;
        if (!w_illegal) begin
          r_op   <= w_op;
          r_func <= w_func;
          r_a    <= w_g1 ? io_bus.req1_a : io_bus.req0_a;
          r_b    <= w_g1 ? io_bus.req1_b : io_bus.req0_b;
        end
      end
      if (r_state == ISSUE) r_result <= io_bus.alu_result;
    end
  end
  assign io_bus.req0_ready = w_g0;
  assign io_bus.req1_ready = w_g1;
  assign io_bus.alu_op     = r_op;
  assign io_bus.func_code  = r_func;
  assign io_bus.alu_a      = r_a;
  assign io_bus.alu_b      = r_b;
  assign io_bus.rsp_valid  = r_state == RESP;
  assign io_bus.rsp_id     = r_id;
  assign io_bus.rsp_tag    = r_tag;
  assign io_bus.rsp_result = r_result;
  assign io_bus.rsp_err    = r_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for alu_share_arbiter with a small ALU model on the shared pins
module tb_alu_share_arbiter;
  logic clk, rst;
  alu_share_if #(.DATA_W(32), .TAG_W(4)) bus ();
  alu_share_arbiter #(.DATA_W(32), .TAG_W(4)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  typedef struct packed {logic id; logic [3:0] tag; logic [31:0] res; logic err;} rsp_t;
  rsp_t sb[$];
  int   gnt_id[$], gnt_cyc[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [31:0] alu_model(logic [3:0] op, logic [5:0] f, logic [31:0] a, logic [31:0] b);
    if (op == 4'b0010) return a + b;
    if (op == 4'b0110) return a - b;
    if (op == 4'b1111) return f == 6'h20 ? a + b : f == 6'h22 ? a - b : a ^ b;
    return a & b;
  endfunction
  function automatic logic illegal(logic [3:0] op, logic [5:0] f);
`ifdef ILLEGAL_FUNC_TRAP_EN
    return op == 4'b0101 || (op == 4'b1111 && !(f inside
      {6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}));
`else
    return 1'b0;
`endif
  endfunction
  always_comb bus.alu_result = alu_model(bus.alu_op, bus.func_code, bus.alu_a, bus.alu_b);
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req(int n, logic v, logic [3:0] op, logic [5:0] f, logic [31:0] a, logic [31:0] b, logic [3:0] tag);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_alu_op = op; bus.req0_func = f;
      bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = v; bus.req1_alu_op = op; bus.req1_func = f;
      bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
    end
  endtask
  // Observe handshakes just before the rising edge, then advance to the next falling edge
  task automatic tick();
    rsp_t e;
    #1;
    chk("one_ready", bus.req0_ready & bus.req1_ready, 0);
    if (bus.req0_ready) begin
      e.id = 0; e.tag = bus.req0_tag; e.err = illegal(bus.req0_alu_op, bus.req0_func);
      e.res = e.err ? 32'd0 : alu_model(bus.req0_alu_op, bus.req0_func, bus.req0_a, bus.req0_b);
      sb.push_back(e); gnt_id.push_back(0); gnt_cyc.push_back(cyc);
    end
    if (bus.req1_ready) begin
      e.id = 1; e.tag = bus.req1_tag; e.err = illegal(bus.req1_alu_op, bus.req1_func);
      e.res = e.err ? 32'd0 : alu_model(bus.req1_alu_op, bus.req1_func, bus.req1_a, bus.req1_b);
      sb.push_back(e); gnt_id.push_back(1); gnt_cyc.push_back(cyc);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_id", bus.rsp_id, e.id);
        chk("sb_tag", bus.rsp_tag, e.tag);
        chk("sb_result", bus.rsp_result, e.res);
        chk("sb_err", bus.rsp_err, e.err);
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic zero_check(string t);
    chk({t, "_rdy0"}, bus.req0_ready, 0);
    chk({t, "_rdy1"}, bus.req1_ready, 0);
    chk({t, "_rspv"}, bus.rsp_valid, 0);
    chk({t, "_aluop"}, bus.alu_op, 0);
    chk({t, "_func"}, bus.func_code, 0);
    chk({t, "_alua"}, bus.alu_a, 0);
    chk({t, "_alub"}, bus.alu_b, 0);
    chk({t, "_id"}, bus.rsp_id, 0);
    chk({t, "_tag"}, bus.rsp_tag, 0);
    chk({t, "_res"}, bus.rsp_result, 0);
    chk({t, "_err"}, bus.rsp_err, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    req(0, 0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0, 0);
    bus.rsp_ready = 1;
    #1;
    zero_check("rst");
    sb.delete(); gnt_id.delete(); gnt_cyc.delete();
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    rst = 1;
    req(0, 0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0, 0);
    bus.rsp_ready = 1;
    @(negedge clk);
    do_reset();
    // Basic op: grant, issue on ALU pins, response two cycles after acceptance
    req(0, 1, 4'b0010, 0, 5, 7, 3);
    #1;
    chk("t1_rdy0", bus.req0_ready, 1);
    chk("t1_rdy1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    #1;
    chk("t1_aluop", bus.alu_op, 4'b0010);
    chk("t1_alua", bus.alu_a, 5);
    chk("t1_alub", bus.alu_b, 7);
    chk("t1_rspv_issue", bus.rsp_valid, 0);
    tick();
    #1;
    chk("t1_rspv", bus.rsp_valid, 1);
    chk("t1_res", bus.rsp_result, 12);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_tag", bus.rsp_tag, 3);
    chk("t1_err", bus.rsp_err, 0);
    tick();
    #1;
    chk("t1_rspv_done", bus.rsp_valid, 0);
    // Both requesters valid continuously: strict alternation, one grant per three cycles
    do_reset();
    repeat (12) begin
      req(0, 1, $urandom_range(0, 1) ? 4'b0010 : 4'b0110, 0, $urandom, $urandom, 4'($urandom));
      req(1, 1, $urandom_range(0, 1) ? 4'b0010 : 4'b0110, 0, $urandom, $urandom, 4'($urandom));
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (3) tick();
    chk("t2_ngrants", gnt_id.size(), 4);
    for (int i = 0; i < gnt_id.size(); i++) chk("t2_gnt_order", gnt_id[i], i % 2);
    for (int i = 1; i < gnt_cyc.size(); i++) chk("t2_gnt_gap", gnt_cyc[i] - gnt_cyc[i-1], 3);
    chk("t2_sb_drained", sb.size(), 0);
    // Response back-pressure: outputs hold, no grants while stalled
    req(0, 1, 4'b0110, 0, 100, 1, 9);
    bus.rsp_ready = 0;
    tick();
    req(1, 1, 4'b0010, 0, 1, 1, 5);
    tick();
    repeat (5) begin
      #1;
      chk("t3_rspv", bus.rsp_valid, 1);
      chk("t3_res", bus.rsp_result, 99);
      chk("t3_tag", bus.rsp_tag, 9);
      chk("t3_id", bus.rsp_id, 0);
      chk("t3_rdy0", bus.req0_ready, 0);
      chk("t3_rdy1", bus.req1_ready, 0);
      tick();
    end
    bus.rsp_ready = 1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
    #1;
    chk("t3_rspv_done", bus.rsp_valid, 0);
    chk("t3_sb_drained", sb.size(), 0);
    // Reset during ISSUE discards the op and restores req0 priority
    req(1, 1, 4'b0010, 0, 1, 2, 4);
    tick();
    bus.req1_valid = 0;
    #1;
    rst = 1;
    #1;
    zero_check("t4");
    sb.delete(); gnt_id.delete(); gnt_cyc.delete();
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      #1;
      chk("t4_no_rsp", bus.rsp_valid, 0);
      tick();
    end
    req(0, 1, 4'b0010, 0, 20, 22, 1);
    req(1, 1, 4'b0010, 0, 30, 33, 2);
    #1;
    chk("t4_rdy0", bus.req0_ready, 1);
    chk("t4_rdy1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (3) tick();
    chk("t4_sb_drained", sb.size(), 0);
    // Func-code op 1111/01: trapped when the trap is built in, issued otherwise
    req(0, 1, 4'b0010, 0, 10, 20, 1);
    tick();
    bus.req0_valid = 0;
    repeat (3) tick();
    req(0, 1, 4'b1111, 6'h01, 3, 4, 6);
    tick();
    bus.req0_valid = 0;
    #1;
`ifdef ILLEGAL_FUNC_TRAP_EN
    chk("t5_rspv", bus.rsp_valid, 1);
    chk("t5_err", bus.rsp_err, 1);
    chk("t5_res", bus.rsp_result, 0);
    chk("t5_tag", bus.rsp_tag, 6);
    chk("t5_aluop_kept", bus.alu_op, 4'b0010);
    chk("t5_func_kept", bus.func_code, 0);
    chk("t5_alua_kept", bus.alu_a, 10);
    chk("t5_alub_kept", bus.alu_b, 20);
    tick();
    req(1, 1, 4'b0101, 0, 7, 8, 11);
    tick();
    bus.req1_valid = 0;
    #1;
    chk("t5_op5_rspv", bus.rsp_valid, 1);
    chk("t5_op5_err", bus.rsp_err, 1);
    chk("t5_op5_id", bus.rsp_id, 1);
    tick();
`else
    chk("t5_rspv_issue", bus.rsp_valid, 0);
    chk("t5_aluop", bus.alu_op, 4'b1111);
    chk("t5_func", bus.func_code, 6'h01);
    chk("t5_alua", bus.alu_a, 3);
    chk("t5_alub", bus.alu_b, 4);
    tick();
    #1;
    chk("t5_rspv", bus.rsp_valid, 1);
    chk("t5_err", bus.rsp_err, 0);
    chk("t5_res", bus.rsp_result, 7);
    tick();
`endif
    repeat (2) tick();
    chk("t5_sb_drained", sb.size(), 0);
    // Lone req1 granted despite Prio=0, then tie goes to req0
    do_reset();
    req(1, 1, 4'b0010, 0, 8, 9, 2);
    #1;
    chk("t6_rdy1", bus.req1_ready, 1);
    chk("t6_rdy0", bus.req0_ready, 0);
    tick();
    bus.req1_valid = 0;
    repeat (2) tick();
    req(0, 1, 4'b0110, 0, 50, 8, 12);
    req(1, 1, 4'b0010, 0, 60, 9, 13);
    #1;
    chk("t6_tie_rdy0", bus.req0_ready, 1);
    chk("t6_tie_rdy1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (3) tick();
    chk("final_sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
